// File: rtl/npc_pkg.sv
// npc_pkg -- shared constants and types for the NPC core back end.
//
// Contents:
//   XLEN            default integer register width
//   NR_GPR          number of architectural integer registers
//   GPR_AW          register index width
//   A0_IDX          index of a0 (x10), which carries the exit code at ebreak
//   commit_state_e  write-back/commit stage states (RUN, DRAIN, HALT)
package npc_pkg;

    localparam int XLEN   = 64;
    localparam int NR_GPR = 32;
    localparam int GPR_AW = $clog2(NR_GPR);
    localparam int A0_IDX = 10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } commit_state_e;

endpackage

// File: rtl/gpr_regfile.sv
// gpr_regfile -- 32 x XLEN integer register file.
//
// One synchronous write port, two combinational read ports with same-cycle
// bypass from the write port, and a flattened view of all registers.
// x0 is hardwired to zero on every read path.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears all regs)
//   we, waddr, wdata    write port (writes to x0 are dropped)
//   rs1_addr, rs1_data  read port 1 (bypassed)
//   rs2_addr, rs2_data  read port 2 (bypassed)
//   rf_flat             xk = rf_flat[XLEN*k +: XLEN]
module gpr_regfile
    import npc_pkg::*;
#(
    parameter int XLEN = npc_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [GPR_AW-1:0]        waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [GPR_AW-1:0]        rs1_addr,
    input  logic [GPR_AW-1:0]        rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic [NR_GPR*XLEN-1:0]   rf_flat
);

    logic [XLEN-1:0] regs [NR_GPR];

    // Reset takes priority so a write presented in the reset cycle is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_GPR; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // A write landing this cycle is forwarded so decode sees it immediately.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = (we && (waddr == rs1_addr)) ? wdata : regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_data = (we && (waddr == rs2_addr)) ? wdata : regs[rs2_addr];
        end
    end

    for (genvar k = 0; k < NR_GPR; k++) begin : g_flat
        if (k == 0) begin : g_zero
            assign rf_flat[k*XLEN +: XLEN] = '0;
        end else begin : g_reg
            assign rf_flat[k*XLEN +: XLEN] = regs[k];
        end
    end

endmodule

// File: rtl/wb_commit.sv
// wb_commit -- write-back/commit stage of the single-issue NPC core.
//
// Retires one instruction per cycle over wb_valid/wb_ready, writes the
// integer register file, and on ebreak drains for DRAIN_CYCLES cycles before
// raising a sticky halt (is_break). exit_code captures a0 at ebreak accept.
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN after ebreak (0 goes straight to HALT)
//   XLEN          register width
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   wb_valid / wb_ready             retire handshake (ready only in RUN)
//   wb_pc, wb_inst                  retiring instruction PC and word
//   wb_wen, wb_rd, wb_wdata         register write request
//   wb_ebreak                       retiring instruction is ebreak
//   rs1_addr/rs1_data, rs2_addr/rs2_data  bypassed decode read ports
//   rf_flat                         flattened architectural registers
//   commit_valid/commit_pc/commit_inst    registered retire report
//   is_break                        sticky halt flag
//   exit_code                       a0 at ebreak accept
//
// Optional feature (macro WB_COMMIT_PERF_EN):
//   cycle_cnt    cycles while not halted, frozen in HALT
//   instret_cnt  accepted instructions, including ebreak
module wb_commit
    import npc_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int XLEN         = npc_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [63:0]              wb_pc,
    input  logic [31:0]              wb_inst,
    input  logic                     wb_wen,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_wdata,
    input  logic                     wb_ebreak,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic [NR_GPR*XLEN-1:0]   rf_flat,
    output logic                     commit_valid,
    output logic [63:0]              commit_pc,
    output logic [31:0]              commit_inst,
    output logic                     is_break,
    output logic [XLEN-1:0]          exit_code
`ifdef WB_COMMIT_PERF_EN
    ,
    output logic [63:0]              cycle_cnt,
    output logic [63:0]              instret_cnt
`endif
);

    // Counter only ever holds DRAIN_CYCLES-1 down to 0.
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    commit_state_e    state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             accept;
    logic             rf_we;

    assign wb_ready = (state_q == ST_RUN);
    assign accept   = wb_valid && wb_ready;
    // ebreak never writes its rd, even if wb_wen happens to be set.
    assign rf_we    = accept && wb_wen && !wb_ebreak;

    gpr_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (wb_rd),
        .wdata    (wb_wdata),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rf_flat  (rf_flat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept && wb_ebreak) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_HALT;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // is_break follows the state register by one cycle, so it rises
    // DRAIN_CYCLES+1 edges after the ebreak accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_inst  <= '0;
            is_break     <= 1'b0;
            exit_code    <= '0;
        end else begin
            commit_valid <= accept;
            is_break     <= (state_q == ST_HALT);
            if (accept) begin
                commit_pc   <= wb_pc;
                commit_inst <= wb_inst;
                if (wb_ebreak) begin
                    exit_code <= rf_flat[A0_IDX*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef WB_COMMIT_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_q != ST_HALT) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (accept) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit -- randomized scoreboard bench for wb_commit.
//
// A driver issues one vector per cycle and keeps a behavioural model of the
// architectural state (register array, ebreak edge, exit code, counters).
// Every accepted instruction pushes its expected commit record into a queue;
// a monitor pops and compares whenever the DUT reports a commit.
module tb_wb_commit;

    localparam int XLEN  = 64;
    localparam int DRAIN = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [63:0]          wb_pc;
    logic [31:0]          wb_inst;
    logic                 wb_wen;
    logic [4:0]           wb_rd;
    logic [XLEN-1:0]      wb_wdata;
    logic                 wb_ebreak;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [32*XLEN-1:0]   rf_flat;
    logic                 commit_valid;
    logic [63:0]          commit_pc;
    logic [31:0]          commit_inst;
    logic                 is_break;
    logic [XLEN-1:0]      exit_code;
`ifdef WB_COMMIT_PERF_EN
    logic [63:0]          cycle_cnt;
    logic [63:0]          instret_cnt;
`endif

    always #5 clk = ~clk;

    wb_commit #(
        .DRAIN_CYCLES (DRAIN),
        .XLEN         (XLEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_pc        (wb_pc),
        .wb_inst      (wb_inst),
        .wb_wen       (wb_wen),
        .wb_rd        (wb_rd),
        .wb_wdata     (wb_wdata),
        .wb_ebreak    (wb_ebreak),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rf_flat      (rf_flat),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .is_break     (is_break),
        .exit_code    (exit_code)
`ifdef WB_COMMIT_PERF_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    typedef struct {
        int unsigned        due;
        logic [63:0]        pc;
        logic [31:0]        inst;
        logic [XLEN-1:0]    rf [32];
    } commit_t;

    commit_t           sb_q [$];

    logic [XLEN-1:0]   mrf [32];
    int unsigned       edge_idx;
    bit                m_ebreaked;
    int unsigned       m_eb_edge;
    logic [XLEN-1:0]   m_exit;
    logic [63:0]       m_pc;
    logic [31:0]       m_inst;
    longint unsigned   m_cycle;
    longint unsigned   m_instret;
    int                vectors;
    int                miscompares;
    bit                mon_en;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] rf_reg(input int k);
        return rf_flat[k*XLEN +: XLEN];
    endfunction

    // The stage stalls from the ebreak accept onward until reset.
    function automatic bit model_ready();
        return !m_ebreaked;
    endfunction

    // Halt is visible once DRAIN+1 edges have passed since the accept edge.
    function automatic bit model_halt();
        return m_ebreaked && (edge_idx >= m_eb_edge + DRAIN + 2);
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [4:0] a, input bit wr,
                                                   input logic [4:0] rd, input logic [XLEN-1:0] wd);
        if (a == 5'd0) return '0;
        if (wr && rd == a) return wd;
        return mrf[a];
    endfunction

    task automatic checkOutput(input bit wr, input logic [4:0] rd, input logic [XLEN-1:0] wd);
        check("wb_ready", {63'd0, wb_ready}, {63'd0, model_ready()});
        check("is_break", {63'd0, is_break}, {63'd0, model_halt()});
        check("exit_code", exit_code, m_exit);
        check("commit_pc", commit_pc, m_pc);
        check("commit_inst", {32'd0, commit_inst}, {32'd0, m_inst});
        check("rs1_data", rs1_data, model_read(rs1_addr, wr, rd, wd));
        check("rs2_data", rs2_data, model_read(rs2_addr, wr, rd, wd));
        for (int k = 0; k < 32; k++) begin
            check($sformatf("rf_x%0d", k), rf_reg(k), (k == 0) ? '0 : mrf[k]);
        end
`ifdef WB_COMMIT_PERF_EN
        check("cycle_cnt", cycle_cnt, m_cycle);
        check("instret_cnt", instret_cnt, m_instret);
`endif
    endtask

    // Drives one cycle: inputs after the falling edge, checks, then models the edge.
    task automatic applyStimulus(input bit rst, input bit valid, input logic [63:0] pc,
                                 input logic [31:0] inst, input bit wen, input logic [4:0] rd,
                                 input logic [XLEN-1:0] wd, input bit ebreak,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
        bit      accept;
        bit      wr;
        commit_t item;
        rst_n     = !rst;
        wb_valid  = valid;
        wb_pc     = pc;
        wb_inst   = inst;
        wb_wen    = wen;
        wb_rd     = rd;
        wb_wdata  = wd;
        wb_ebreak = ebreak;
        rs1_addr  = ra1;
        rs2_addr  = ra2;
        #2;
        accept = !rst && valid && model_ready();
        wr     = accept && wen && !ebreak && (rd != 5'd0);
        if (!rst) checkOutput(wr, rd, wd);
        if (accept) begin
            item.due  = edge_idx;
            item.pc   = pc;
            item.inst = inst;
            for (int k = 0; k < 32; k++) item.rf[k] = mrf[k];
            if (wr) item.rf[rd] = wd;
            sb_q.push_back(item);
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) mrf[k] = '0;
            m_ebreaked = 1'b0;
            m_exit     = '0;
            m_pc       = '0;
            m_inst     = '0;
            m_cycle    = 0;
            m_instret  = 0;
        end else begin
            if (!(m_ebreaked && edge_idx > m_eb_edge + DRAIN)) m_cycle++;
            if (accept) begin
                m_instret++;
                m_pc   = pc;
                m_inst = inst;
                if (ebreak) begin
                    m_ebreaked = 1'b1;
                    m_eb_edge  = edge_idx;
                    m_exit     = mrf[10];
                end else if (wr) begin
                    mrf[rd] = wd;
                end
            end
        end
        edge_idx++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, '0, '0, 0, 5'd10, 5'd5);
    endtask

    task automatic randomOps(input int n, input int valid_pct);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, ($urandom_range(99) < valid_pct), {$urandom, $urandom}, $urandom,
                          $urandom_range(1), 5'($urandom_range(31)), {$urandom, $urandom}, 0,
                          5'($urandom_range(31)), 5'($urandom_range(31)));
        end
    endtask

    // Commits are checked as soon as the DUT reports them, independent of the driver.
    initial begin
        commit_t item;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb_q.size() > 0 && sb_q[0].due == edge_idx - 1) begin
                    item = sb_q.pop_front();
                    check("commit_valid", {63'd0, commit_valid}, 64'd1);
                    check("commit_pc_pulse", commit_pc, item.pc);
                    check("commit_inst_pulse", {32'd0, commit_inst}, {32'd0, item.inst});
                    for (int k = 0; k < 32; k++) begin
                        check($sformatf("commit_rf_x%0d", k), rf_reg(k), item.rf[k]);
                    end
                end else begin
                    check("commit_valid_idle", {63'd0, commit_valid}, 64'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        edge_idx    = 0;
        m_eb_edge   = 0;
        @(negedge clk);

        $display("[TB] reset");
        applyStimulus(1, 0, '0, '0, 0, '0, '0, 0, '0, '0);
        applyStimulus(1, 0, '0, '0, 0, '0, '0, 0, '0, '0);
        mon_en = 1'b1;

        $display("[TB] directed writes and bypass");
        applyStimulus(0, 1, 64'h8000_0000, 32'h0000_0293, 1, 5'd5, 64'hDEAD_BEEF, 0, 5'd5, 5'd0);
        applyStimulus(0, 1, 64'h8000_0004, 32'h0000_0013, 1, 5'd0, 64'h1234, 0, 5'd0, 5'd5);
        applyStimulus(0, 1, 64'h8000_0008, 32'h0000_0393, 1, 5'd7, 64'h55, 0, 5'd7, 5'd0);
        idle(1);

        $display("[TB] random traffic");
        randomOps(150, 75);

        $display("[TB] ebreak with a0 = 42");
        applyStimulus(0, 1, 64'h8000_1000, 32'h0000_0513, 1, 5'd10, 64'd42, 0, 5'd10, 5'd0);
        applyStimulus(0, 1, 64'h8000_1004, 32'h0010_0073, 1, 5'd10, 64'h999, 1, 5'd10, 5'd3);
        randomOps(8, 100);

        $display("[TB] reset from halt");
        applyStimulus(1, 0, '0, '0, 0, '0, '0, 0, '0, '0);
        idle(1);

        $display("[TB] reset during drain");
        randomOps(40, 80);
        applyStimulus(0, 1, 64'h8000_2000, 32'h0010_0073, 0, 5'd1, '0, 1, 5'd10, 5'd1);
        randomOps(1, 100);
        applyStimulus(1, 1, 64'h8000_2008, 32'h0000_0093, 1, 5'd1, 64'h77, 0, 5'd1, 5'd2);
        idle(2);

        $display("[TB] second run to halt");
        randomOps(20, 60);
        applyStimulus(0, 1, 64'h8000_3000, 32'h0010_0073, 1, 5'd4, 64'hABCD, 1, 5'd4, 5'd10);
        randomOps(6, 100);
        idle(2);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
# wb_commit

Write-back/commit stage of the single-issue NPC core: accepts one retiring instruction per cycle over a valid/ready handshake and writes the 32×64-bit integer register file. It detects `ebreak`, drains for a fixed number of cycles, then raises a sticky halt. It drives the flattened architectural register state and the halt flag consumed by the simulation DPI model.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: cycles spent in DRAIN after `ebreak` acceptance before halt; 0 skips DRAIN.
- `XLEN`, default 64: register width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  **reset is synchronous and active-low.**
- `wb_valid`  in  1  retiring instruction present.
- `wb_ready`  out  1  stage can accept.
- `wb_pc`  in  64  PC of retiring instruction.
- `wb_inst`  in  32  instruction word.
- `wb_wen`  in  1  instruction writes `wb_rd`.
- `wb_rd`  in  5  destination register.
- `wb_wdata`  in  XLEN  write data.
- `wb_ebreak`  in  1  instruction is `ebreak`.
- `rs1_addr`, `rs2_addr`  in  5 each  decode read addresses.
- `rs1_data`, `rs2_data`  out  XLEN each  read data, with bypass.
- `rf_flat`  out  32·XLEN  architectural registers; xk = bits [XLEN·k+XLEN−1 : XLEN·k].
- `commit_valid`  out  1  one-cycle pulse per retired instruction.
- `commit_pc`  out  64  PC of last retired instruction.
- `commit_inst`  out  32  word of last retired instruction.
- `is_break`  out  1  sticky halt.
- `exit_code`  out  XLEN  x10 (a0) captured at `ebreak` acceptance.

## Operation
- Accept = `wb_valid && wb_ready`. `wb_ready` = 1 in RUN only.
- On accept with `wb_wen` and `wb_rd != 0`: x[wb_rd] ← `wb_wdata`. Writes to x0 are dropped. x0 always reads 0.
- `ebreak` never writes rd, regardless of `wb_wen`.
- Reads are combinational. Bypass: on accept with `wb_wen`, where `rsN_addr == wb_rd != 0`, `rsN_data` = `wb_wdata`.
- FSM states:
  - RUN → DRAIN on accept with `wb_ebreak`, or → HALT if `DRAIN_CYCLES` = 0.
  - DRAIN: down-counter loaded with `DRAIN_CYCLES` − 1; → HALT when the counter reads 0.
  - HALT: terminal; only `rst_n` leaves it.
- `is_break` = 1 iff state is HALT (registered).
- `exit_code` is latched on `ebreak` accept from the current x10.
- `valid` without `ready` in DRAIN/HALT: ignored, no state change. The upstream stage must hold its values.

## Timing
- Reset values (`rst_n` low at edge):
  - state RUN; all x registers 0.
  - `commit_valid` 0; `commit_pc` 0; `commit_inst` 0.
  - `is_break` 0; `exit_code` 0; drain counter 0.
  - Perf counters 0.
- Reset mid-DRAIN or in HALT returns to RUN next cycle; no write from that cycle is retained.
- Write latency: `rf_flat` reflects the write 1 cycle after accept. Read bypass covers the accept cycle itself.
- `commit_valid`/`commit_pc`/`commit_inst` are registered, 1 cycle after accept; `ebreak` also produces a commit pulse.
- `is_break` rises exactly `DRAIN_CYCLES` + 1 cycles after the `ebreak` accept edge.
- Back-to-back accepts in RUN: 1 per cycle, no bubbles.

## Configuration
- `WB_COMMIT_PERF_EN` defined:
  - adds outputs `cycle_cnt` (64) and `instret_cnt` (64).
  - `cycle_cnt` increments every cycle while not HALT.
  - `instret_cnt` increments on every accept, including `ebreak`.
  - Both wrap modulo 2^64 and freeze in HALT.
- Undefined: ports and counters absent.

## Structure
- Shared package `npc_pkg`: `XLEN`, `NR_GPR` = 32, commit-state enum (RUN, DRAIN, HALT), register index of a0 (10).
- One sub-module `gpr_regfile`: 32×XLEN storage, one write port, two bypassed read ports, flat output, x0 hardwired.
- FSM, commit registers and counters live in `wb_commit`.

## Test plan
- Reset, then accept `rd=5, wdata=0xDEAD_BEEF` → x5 = 0xDEADBEEF in `rf_flat` next cycle; `commit_valid` pulse with matching pc.
- Accept `rd=0, wdata=0x1234` with `rs1_addr=0` → x0 and `rs1_data` remain 0.
- Same-cycle accept `rd=7, wdata=0x55` with `rs1_addr=7` → `rs1_data` = 0x55 in that cycle.
- Set x10 = 42, then accept `ebreak` (DRAIN_CYCLES=2) → `wb_ready` low next cycle; `is_break` = 1 three cycles after the accept; `exit_code` = 42; later `wb_valid` ignored.
- HALT, then assert `rst_n` = 0 for one cycle → `is_break` = 0, all x = 0, `wb_ready` = 1.
- With `WB_COMMIT_PERF_EN`: retire 10 instructions plus `ebreak` → `instret_cnt` = 11, `cycle_cnt` frozen after HALT.
